// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with HI/LO result registers.
// Executes MULT/MULTU/DIV/DIVU one bit per cycle and services MTHI/MTLO.
// Sequence: IDLE -> PREP (take magnitudes) -> RUN (WIDTH steps) -> FIX (sign fix, write).
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active HIGH despite the name
//   start, op  launch request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b       operands (rs, rt); a is also the MTHI/MTLO source
//   mthi, mtlo move a into hi / lo (honoured only when idle)
//   hi, lo     result registers
//   busy       operation in flight
//   done       one-cycle pulse when hi/lo take a new result
module mdu_hilo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);

   typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

   state_e               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic                 sign_q, sign_d;
   logic                 sign_r_q, sign_r_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   logic                 is_div;
   logic                 is_signed;
   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       part_rem;
   logic                 rem_ge;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quot;
   logic [WIDTH-1:0]     rem;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      sign_r_d = sign_r_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      dvs_d    = dvs_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      is_div    = op_q[1];
      is_signed = ~op_q[0];
      abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
      abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

      add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};
      // Remainder shifted left with the next dividend bit; may need WIDTH+1 bits.
      part_rem = acc_q[2*WIDTH-1:WIDTH-1];
      rem_ge   = (part_rem >= {1'b0, dvs_q});

      prod = (is_signed && sign_q) ? -acc_q : acc_q;
      quot = (is_signed && sign_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem  = (is_signed && sign_r_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      unique case (state_q)
         StIdle: begin
            if (mthi) hi_d = a;
            if (mtlo) lo_d = a;
            if (start) begin
               op_d    = op;
               a_d     = a;
               b_d     = b;
               state_d = StPrep;
            end
         end
         StPrep: begin
            sign_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
            sign_r_d = a_q[WIDTH-1];
            acc_d    = {{WIDTH{1'b0}}, abs_a};
            dvs_d    = abs_b;
            cnt_d    = CntInit;
            state_d  = StRun;
         end
         StRun: begin
            if (is_div) begin
               // Restoring step; when rem_ge the difference is below the divisor, so it fits WIDTH.
               if (rem_ge) acc_d = {part_rem[WIDTH-1:0] - dvs_q, acc_q[WIDTH-2:0], 1'b1};
               else        acc_d = {part_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
               if (acc_q[0]) acc_d = {add_sum, acc_q[WIDTH-1:1]};
               else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0) state_d = StFix;
         end
         StFix: begin
            if (is_div && (b_q == '0)) begin
               lo_d = '1;
               hi_d = a_q;
            end else if (is_div) begin
               lo_d = quot;
               hi_d = rem;
            end else begin
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         sign_r_q <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         dvs_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         sign_r_q <= sign_r_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         dvs_q    <= dvs_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != StIdle);
   assign done = done_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed self-checking bench for mdu_hilo (WIDTH=32).
module tb_mdu_hilo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mdu_hilo #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Edge E0 accepts the op; operands are scrambled afterwards to prove they were latched.
   task automatic launch(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv);
      op    = o;
      a     = av;
      b     = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0BAD_F00D;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   // Counts edges after E0 until done; result must land exactly at E34.
   task automatic wait_done(input string tag, input int already);
      int n;
      n = already;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 32'd34);
      chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      launch(tag, o, av, bv);
      wait_done(tag, 0);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
      tick();
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_hi_hold"}, hi, exp_hi);
   endtask

   initial begin
      int seen_done;
      rst_n = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_negdivisor", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("divu_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
      run_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // mthi and mtlo together in idle.
      a    = 32'hA5A5_A5A5;
      mthi = 1'b1;
      mtlo = 1'b1;
      tick();
      mthi = 1'b0;
      mtlo = 1'b0;
      chk("mt_both_hi", hi, 32'hA5A5_A5A5);
      chk("mt_both_lo", lo, 32'hA5A5_A5A5);
      chk("mt_both_done", {31'd0, done}, 32'd0);

      // start and mthi while busy are both ignored.
      launch("mult_busy", 2'b00, 32'd6, 32'd7);
      for (int i = 0; i < 9; i++) tick();
      op    = 2'b11;
      a     = 32'h55;
      start = 1'b1;
      mthi  = 1'b1;
      tick();
      start = 1'b0;
      mthi  = 1'b0;
      chk("busy_mthi_ignored", hi, 32'hA5A5_A5A5);
      wait_done("mult_busy", 10);
      chk("mult_busy_hi", hi, 32'h0);
      chk("mult_busy_lo", lo, 32'd42);
      tick();
      chk("mult_busy_idle", {31'd0, busy}, 32'd0);

      // Move and launch in the same idle cycle: move first, result overwrites later.
      op    = 2'b01;
      a     = 32'd2;
      b     = 32'd3;
      start = 1'b1;
      mthi  = 1'b1;
      tick();
      start = 1'b0;
      mthi  = 1'b0;
      chk("same_cyc_mthi", hi, 32'd2);
      wait_done("same_cyc", 0);
      chk("same_cyc_hi", hi, 32'h0);
      chk("same_cyc_lo", lo, 32'd6);
      tick();

      // Reset mid-operation discards the op.
      launch("div_rst", 2'b10, 32'd100, 32'd3);
      for (int i = 0; i < 14; i++) tick();
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hi", hi, 32'h0);
      chk("midrst_lo", lo, 32'h0);
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) seen_done = 1;
         tick();
      end
      chk("midrst_no_done", seen_done, 32'd0);
      a    = 32'h1234;
      mtlo = 1'b1;
      tick();
      mtlo = 1'b0;
      chk("mtlo_lo", lo, 32'h1234);
      chk("mtlo_hi", hi, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
